// File: rtl/nxs_pkg.sv
// Shared constants and types for the nonce scheduler.
// Pipeline latency is four hash blocks of 101 stages each.
package nxs_pkg;

  localparam int NONCE_W      = 64;
  localparam int STAGESPERBLK = 101;
  localparam int PIPE_LATENCY = 4 * STAGESPERBLK;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/nxs_result_fifo.sv
// Result FIFO with registered head data and registered full/empty flags.
// A push into a full FIFO only lands when a pop happens in the same cycle.
module nxs_result_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 64
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             full_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             empty_q, full_q;
  logic             wr_en, rd_en;

  assign rd_en = pop_i && !empty_q;
  assign wr_en = push_i && (!full_q || rd_en);

  always_comb begin
    wptr_d = wptr_q + AW'(wr_en);
    rptr_d = rptr_q + AW'(rd_en);
    cnt_d  = cnt_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);
    // New head is the word being written when the slot coincides
    data_d = (wr_en && (wptr_q == rptr_d)) ? data_i : mem_q[rptr_d];
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wptr_q] <= data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      empty_q <= (cnt_d == '0);
      full_q  <= (cnt_d == (AW+1)'(DEPTH));
    end
  end

  assign data_o  = data_q;
  assign valid_o = !empty_q;
  assign full_o  = full_q;

endmodule

// File: rtl/nxs_nonce_scheduler.sv
// Issues a nonce range into the hash pipeline and collects passing nonces.
// A 1-bit epoch tags in-flight work so a reload discards stale results.
module nxs_nonce_scheduler #(
  parameter int NONCE_W      = nxs_pkg::NONCE_W,
  parameter int PIPE_LATENCY = nxs_pkg::PIPE_LATENCY,
  parameter int FIFO_DEPTH   = 8,
  parameter int CMP_W        = 64
) (
  input  logic               clk,
  input  logic               nHashRst,
  input  logic               work_load,
  input  logic [NONCE_W-1:0] start_nonce,
  input  logic [NONCE_W-1:0] nonce_count,
  input  logic [CMP_W-1:0]   target,
  input  logic               issue_ready,
  output logic               issue_valid,
  output logic [NONCE_W-1:0] issue_nonce,
  input  logic               hash_valid,
  input  logic [CMP_W-1:0]   hash_out,
  output logic               res_valid,
  output logic [NONCE_W-1:0] res_nonce,
  input  logic               res_ready,
  output logic               busy,
  output logic               done,
  output logic               overflow,
  output logic               seq_err
);

  localparam int CNT_W = $clog2(PIPE_LATENCY + 1);

  nxs_pkg::state_t state_q, state_d;

  logic [NONCE_W-1:0]    nonce_q, nonce_d;
  logic [NONCE_W-1:0]    rem_q, rem_d;
  logic [CMP_W-1:0]      target_q;
  logic                  epoch_q;
  logic [PIPE_LATENCY-1:0] iss_q;
  logic [NONCE_W:0]      dl_q [PIPE_LATENCY];
  logic [CNT_W-1:0]      cnt0_q, cnt0_d;
  logic [CNT_W-1:0]      cnt1_q, cnt1_d;
  logic                  match_q, match_d;
  logic [NONCE_W-1:0]    mnonce_q;
  logic                  ovf_q, serr_q;
  logic                  done_q, done_d;

  logic                  fire;
  logic                  tap_iss, tap_ep;
  logic [NONCE_W-1:0]    tap_nonce;
  logic                  drain_empty;
  logic                  fifo_full, drop;

  assign issue_valid = (state_q == nxs_pkg::ST_RUN)
                     && (rem_q != '0) && !work_load;
  assign issue_nonce = nonce_q;
  assign fire        = issue_valid && issue_ready;

  assign tap_iss = iss_q[PIPE_LATENCY-1];
  assign {tap_ep, tap_nonce} = dl_q[PIPE_LATENCY-1];

  // In-flight issue counts per epoch value
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (fire && !epoch_q)   cnt0_d = cnt0_d + CNT_W'(1);
    if (fire && epoch_q)    cnt1_d = cnt1_d + CNT_W'(1);
    if (tap_iss && !tap_ep) cnt0_d = cnt0_d - CNT_W'(1);
    if (tap_iss && tap_ep)  cnt1_d = cnt1_d - CNT_W'(1);
  end

  assign drain_empty = epoch_q ? (cnt1_q == '0) : (cnt0_q == '0);

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    nonce_d = nonce_q;
    rem_d   = rem_q;
    if (work_load) begin
      state_d = nxs_pkg::ST_RUN;
      nonce_d = start_nonce;
      rem_d   = nonce_count;
    end else begin
      if (fire) begin
        nonce_d = nonce_q + NONCE_W'(1);
        rem_d   = rem_q - NONCE_W'(1);
      end
      case (state_q)
        nxs_pkg::ST_RUN: begin
          if ((rem_q == '0) || (fire && (rem_q == NONCE_W'(1))))
            state_d = nxs_pkg::ST_DRAIN;
        end
        nxs_pkg::ST_DRAIN: begin
          if (drain_empty) begin
            state_d = nxs_pkg::ST_IDLE;
            done_d  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign match_d = hash_valid && tap_iss && (tap_ep == epoch_q)
                 && (hash_out <= target_q) && !work_load;

  assign drop = match_q && fifo_full && !(res_ready && res_valid);

  // Data half of the delay line carries no reset so it maps to shift RAM
  always_ff @(posedge clk) begin
    dl_q[0] <= {epoch_q, nonce_q};
    for (int i = 1; i < PIPE_LATENCY; i++) dl_q[i] <= dl_q[i-1];
  end

  always_ff @(posedge clk or negedge nHashRst) begin
    if (!nHashRst) begin
      state_q  <= nxs_pkg::ST_IDLE;
      nonce_q  <= '0;
      rem_q    <= '0;
      target_q <= '0;
      epoch_q  <= 1'b0;
      iss_q    <= '0;
      cnt0_q   <= '0;
      cnt1_q   <= '0;
      match_q  <= 1'b0;
      mnonce_q <= '0;
      ovf_q    <= 1'b0;
      serr_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      nonce_q  <= nonce_d;
      rem_q    <= rem_d;
      iss_q    <= {iss_q[PIPE_LATENCY-2:0], fire};
      cnt0_q   <= cnt0_d;
      cnt1_q   <= cnt1_d;
      match_q  <= match_d;
      mnonce_q <= tap_nonce;
      done_q   <= done_d;
      if (work_load) begin
        target_q <= target;
        epoch_q  <= ~epoch_q;
        ovf_q    <= 1'b0;
        serr_q   <= 1'b0;
      end else begin
        if (drop) ovf_q <= 1'b1;
        if (hash_valid != tap_iss) serr_q <= 1'b1;
      end
    end
  end

  nxs_result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (NONCE_W)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (nHashRst),
    .push_i  (match_q),
    .data_i  (mnonce_q),
    .pop_i   (res_ready),
    .data_o  (res_nonce),
    .valid_o (res_valid),
    .full_o  (fifo_full)
  );

  assign busy     = (state_q != nxs_pkg::ST_IDLE);
  assign done     = done_q;
  assign overflow = ovf_q;
  assign seq_err  = serr_q;

endmodule

// File: tb/tb_nxs_nonce_scheduler.sv
// Bench for nxs_nonce_scheduler: table of jobs, random jobs and
// hand-written reload / reset sequences against a behavioural model.
module tb_nxs_nonce_scheduler;

  localparam int NW = 64;
  localparam int HW = 64;
  localparam int P  = 404;
  localparam int FD = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          nHashRst;
  logic          work_load;
  logic [NW-1:0] start_nonce, nonce_count;
  logic [HW-1:0] target;
  logic          issue_ready, issue_valid;
  logic [NW-1:0] issue_nonce;
  logic          hash_valid;
  logic [HW-1:0] hash_out;
  logic          res_valid, res_ready;
  logic [NW-1:0] res_nonce;
  logic          busy, done, overflow, seq_err;

  nxs_nonce_scheduler #(
    .NONCE_W      (NW),
    .PIPE_LATENCY (P),
    .FIFO_DEPTH   (FD),
    .CMP_W        (HW)
  ) dut (
    .clk         (clk),
    .nHashRst    (nHashRst),
    .work_load   (work_load),
    .start_nonce (start_nonce),
    .nonce_count (nonce_count),
    .target      (target),
    .issue_ready (issue_ready),
    .issue_valid (issue_valid),
    .issue_nonce (issue_nonce),
    .hash_valid  (hash_valid),
    .hash_out    (hash_out),
    .res_valid   (res_valid),
    .res_nonce   (res_nonce),
    .res_ready   (res_ready),
    .busy        (busy),
    .done        (done),
    .overflow    (overflow),
    .seq_err     (seq_err)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int job_L    = 0;
  int inject_at = -1;
  int mode     = 0;
  int first_res_cyc = -1;
  int done_cnt = 0;
  logic [HW-1:0] cur_tgt;
  logic [HW-1:0] pend_h [int];
  logic [NW-1:0] got_q [$];
  logic [NW-1:0] iss_q [$];

  typedef struct {
    logic [63:0] s;
    logic [63:0] c;
    logic [63:0] t;
    int          m;
    int          rmode;
    bit          rr;
    int          inj;
    int          exp_n;
    logic [63:0] exp_first;
    logic [63:0] exp_last;
    bit          exp_ovf;
    bit          chk_lat;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Hash model: mode 0 returns the target itself, mode 1 a mixed value
  function automatic logic [HW-1:0] hashf(input logic [NW-1:0] n,
                                          input logic [HW-1:0] tg,
                                          input int m);
    if (m == 0) return tg;
    return n * 64'h9E3779B97F4A7C15;
  endfunction

  // One clock: drive pipeline model, sample mid-cycle, advance
  task automatic tick();
    hash_valid = pend_h.exists(cyc) || (cyc == inject_at);
    hash_out   = pend_h.exists(cyc) ? pend_h[cyc] : '0;
    if (pend_h.exists(cyc)) pend_h.delete(cyc);
    #1;
    if (issue_valid && issue_ready) begin
      iss_q.push_back(issue_nonce);
      pend_h[cyc + P] = hashf(issue_nonce, cur_tgt, mode);
    end
    if (res_valid && res_ready) got_q.push_back(res_nonce);
    if (res_valid && first_res_cyc < 0) first_res_cyc = cyc;
    if (done) done_cnt++;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_job(input string nm, input logic [63:0] s,
                         input logic [63:0] c, input logic [63:0] t,
                         input int m, input int rmode, input bit rr,
                         input int inj);
    logic [NW-1:0] exp_q [$];
    logic [NW-1:0] n;
    bit exp_ovf;
    int budget;
    got_q.delete();
    iss_q.delete();
    done_cnt = 0;
    first_res_cyc = -1;
    mode = m;
    cur_tgt = t;
    for (int i = 0; i < int'(c); i++) begin
      n = s + 64'(i);
      if (hashf(n, t, m) <= t) exp_q.push_back(n);
    end
    exp_ovf = 1'b0;
    if (!rr && exp_q.size() > FD) exp_ovf = 1'b1;
    while (!rr && exp_q.size() > FD) void'(exp_q.pop_back());
    res_ready   = rr;
    issue_ready = 1'b1;
    start_nonce = s;
    nonce_count = c;
    target      = t;
    work_load   = 1'b1;
    job_L       = cyc;
    tick();
    work_load   = 1'b0;
    inject_at   = (inj >= 0) ? job_L + inj : -1;
    check({nm, "_busy"}, 64'(busy), 64'd1);
    check({nm, "_serr_clr"}, 64'(seq_err), 64'd0);
    check({nm, "_ovf_clr"}, 64'(overflow), 64'd0);
    budget = 2 * int'(c) + P + 40;
    for (int k = 0; k < budget && done_cnt == 0; k++) begin
      case (rmode)
        1:       issue_ready = ((cyc - job_L) % 2) == 1;
        2:       issue_ready = 1'($urandom_range(0, 1));
        default: issue_ready = 1'b1;
      endcase
      tick();
    end
    check({nm, "_done"}, 64'(done_cnt), 64'd1);
    repeat (3) tick();
    check({nm, "_done_once"}, 64'(done_cnt), 64'd1);
    check({nm, "_idle"}, 64'(busy), 64'd0);
    check({nm, "_ovf"}, 64'(overflow), 64'(exp_ovf));
    check({nm, "_serr"}, 64'(seq_err), 64'(inj >= 0));
    inject_at = -1;
    res_ready = 1'b1;
    repeat (FD + 3) tick();
    check({nm, "_nres"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check({nm, "_res"}, got_q[i], exp_q[i]);
    check({nm, "_niss"}, 64'(iss_q.size()), c);
    for (int i = 0; i < iss_q.size(); i++)
      check({nm, "_iss"}, iss_q[i], s + 64'(i));
  endtask

  initial begin
    vecs[0] = '{64'h00000001FCAFC044, 64'd1, 64'h000000000E8A504F, 0, 0,
                1'b1, -1, 1, 64'h00000001FCAFC044, 64'h00000001FCAFC044,
                1'b0, 1'b1};
    vecs[1] = '{64'hFFFFFFFFFFFFFFFE, 64'd4, 64'hFFFFFFFFFFFFFFFF, 0, 0,
                1'b1, -1, 4, 64'hFFFFFFFFFFFFFFFE, 64'h1, 1'b0, 1'b0};
    vecs[2] = '{64'h100, 64'd12, 64'h1234, 0, 0,
                1'b0, -1, 8, 64'h100, 64'h107, 1'b1, 1'b0};
    vecs[3] = '{64'h7FFFFFFFFFFFFFF0, 64'd16, 64'h55, 0, 1,
                1'b1, -1, 16, 64'h7FFFFFFFFFFFFFF0, 64'h7FFFFFFFFFFFFFFF,
                1'b0, 1'b0};
    vecs[4] = '{64'h42, 64'd0, 64'h55, 0, 0,
                1'b1, -1, 0, 64'h0, 64'h0, 1'b0, 1'b0};
    vecs[5] = '{64'h2000, 64'd10, 64'h77, 0, 0,
                1'b1, 5, 10, 64'h2000, 64'h2009, 1'b0, 1'b0};
    vecs[6] = '{64'h3000, 64'd30, 64'h6000000000000000, 1, 1,
                1'b1, -1, -1, 64'h0, 64'h0, 1'b0, 1'b0};

    nHashRst    = 1'b0;
    work_load   = 1'b0;
    start_nonce = '0;
    nonce_count = '0;
    target      = '0;
    issue_ready = 1'b0;
    res_ready   = 1'b0;
    hash_valid  = 1'b0;
    hash_out    = '0;
    cur_tgt     = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_issue_valid", 64'(issue_valid), 64'd0);
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_seq_err", 64'(seq_err), 64'd0);
    nHashRst = 1'b1;
    repeat (3) tick();
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_seq_err", 64'(seq_err), 64'd0);

    for (int i = 0; i < 7; i++) begin
      run_job($sformatf("vec%0d", i), vecs[i].s, vecs[i].c, vecs[i].t,
              vecs[i].m, vecs[i].rmode, vecs[i].rr, vecs[i].inj);
      check($sformatf("tbl%0d_ovf", i), 64'(overflow), 64'(vecs[i].exp_ovf));
      if (vecs[i].exp_n >= 0) begin
        check($sformatf("tbl%0d_n", i), 64'(got_q.size()),
              64'(vecs[i].exp_n));
        if (vecs[i].exp_n > 0 && got_q.size() > 0) begin
          check($sformatf("tbl%0d_first", i), got_q[0], vecs[i].exp_first);
          check($sformatf("tbl%0d_last", i), got_q[got_q.size()-1],
                vecs[i].exp_last);
        end
      end
      if (vecs[i].chk_lat)
        check($sformatf("tbl%0d_latency", i), 64'(first_res_cyc),
              64'(job_L + 1 + P + 2));
    end

    for (int r = 0; r < 4; r++)
      run_job($sformatf("rand%0d", r), {$urandom, $urandom},
              64'($urandom_range(1, 40)), {$urandom, $urandom}, 1, 2,
              1'b1, -1);

    // Reload 50 cycles into a 100-nonce run
    got_q.delete();
    mode = 0;
    cur_tgt = 64'hFF;
    res_ready = 1'b1;
    issue_ready = 1'b1;
    start_nonce = 64'h1000;
    nonce_count = 64'd100;
    target = 64'hFF;
    work_load = 1'b1;
    tick();
    work_load = 1'b0;
    repeat (49) tick();
    start_nonce = 64'h5000;
    work_load = 1'b1;
    #1;
    check("reload_wl_wins", 64'(issue_valid), 64'd0);
    tick();
    work_load = 1'b0;
    done_cnt = 0;
    for (int k = 0; k < 2 * 100 + P + 40 && done_cnt == 0; k++) tick();
    check("reload_done", 64'(done_cnt), 64'd1);
    repeat (FD + 3) tick();
    check("reload_nres", 64'(got_q.size()), 64'd100);
    for (int i = 0; i < got_q.size() && i < 100; i++)
      check("reload_res", got_q[i], 64'h5000 + 64'(i));
    check("reload_serr", 64'(seq_err), 64'd0);

    // Reset in the middle of a run
    start_nonce = 64'h9000;
    nonce_count = 64'd100;
    work_load = 1'b1;
    tick();
    work_load = 1'b0;
    repeat (30) tick();
    #2;
    nHashRst = 1'b0;
    #1;
    check("mid_rst_issue_valid", 64'(issue_valid), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_res_valid", 64'(res_valid), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);
    check("mid_rst_overflow", 64'(overflow), 64'd0);
    check("mid_rst_seq_err", 64'(seq_err), 64'd0);
    pend_h.delete();
    @(posedge clk);
    #1;
    cyc++;
    nHashRst = 1'b1;
    got_q.delete();
    first_res_cyc = -1;
    repeat (P + 50) tick();
    check("post_rst_nres", 64'(got_q.size()), 64'd0);
    check("post_rst_res_valid", 64'(first_res_cyc), -64'sd1);
    check("post_rst_busy", 64'(busy), 64'd0);
    check("post_rst_serr", 64'(seq_err), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
